// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state enum, opcode constants and control word type for ctrl_pipe
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

    localparam logic [3:0] R_ADD  = 4'd0;
    localparam logic [3:0] R_LOAD = 4'd1;
    localparam logic [3:0] R_MVFR = 4'd2;
    localparam logic [3:0] R_MVTO = 4'd3;
    localparam logic [3:0] R_OR   = 4'd4;
    localparam logic [3:0] R_XOR  = 4'd5;
    localparam logic [3:0] R_XORR = 4'd6;
    localparam logic [3:0] R_AND  = 4'd7;
    localparam logic [3:0] R_STR  = 4'd8;
    localparam logic [3:0] R_SLT  = 4'd9;
    localparam logic [3:0] R_SEQ  = 4'd10;
    localparam logic [3:0] R_BTRU = 4'd11;
    localparam logic [3:0] R_CLR  = 4'd12;
    localparam logic [3:0] R_NOT  = 4'd13;

    localparam logic [2:0] I_LUT  = 3'd0;
    localparam logic [2:0] I_ADDI = 3'd1;
    localparam logic [2:0] I_SUBI = 3'd2;
    localparam logic [2:0] I_B    = 3'd3;
    localparam logic [2:0] I_LSLI = 3'd4;
    localparam logic [2:0] I_LSRI = 3'd5;

    typedef struct packed {
        logic write_r0;
        logic general_reg_write;
        logic read_mem;
        logic write_mem;
        logic branch;
        logic branch_cond;
        logic lut_signal;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction to control word decoder
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] i_instruction,
    output ctrl_word_t    o_word,
    output logic          o_is_halt,
    output logic          o_is_illegal
);

    logic       w_type;
    logic [3:0] w_ropc;
    logic [2:0] w_iopc;
    logic       w_undef;

    assign w_type = i_instruction[IW-2];
    assign w_ropc = i_instruction[IW-3:IW-6];
    assign w_iopc = i_instruction[IW-3:IW-5];

    // The all-ones halt pattern lands on an undefined R opcode, so it is screened out first.
    assign o_is_halt    = &i_instruction;
    assign o_is_illegal = w_undef && !o_is_halt;

    always_comb begin
        o_word  = '0;
        w_undef = 1'b0;
        if (w_type) begin
            case (w_ropc)
                R_ADD, R_MVTO, R_OR, R_XOR, R_XORR,
                R_AND, R_SLT, R_SEQ, R_NOT: o_word.write_r0 = 1'b1;
                R_LOAD: begin
                    o_word.write_r0 = 1'b1;
                    o_word.read_mem = 1'b1;
                end
                R_MVFR: o_word.general_reg_write = 1'b1;
                R_STR:  o_word.write_mem = 1'b1;
                R_BTRU: begin
                    o_word.branch      = 1'b1;
                    o_word.branch_cond = 1'b1;
                end
                R_CLR: begin
                    o_word.write_r0          = 1'b1;
                    o_word.general_reg_write = 1'b1;
                end
                default: w_undef = 1'b1;
            endcase
        end else begin
            case (w_iopc)
                I_LUT: begin
                    o_word.write_r0   = 1'b1;
                    o_word.lut_signal = 1'b1;
                end
                I_ADDI, I_SUBI, I_LSLI, I_LSRI: o_word.write_r0 = 1'b1;
                I_B:     o_word.branch = 1'b1;
                default: w_undef = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - registered handshaked control stage; CTRL_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int IW      = 9,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IW-1:0]    i_instruction,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    input  logic             i_flush,
    output logic             o_write_r0,
    output logic             o_general_reg_write,
    output logic             o_read_mem,
    output logic             o_write_mem,
    output logic             o_branch,
    output logic             o_branch_cond,
    output logic             o_lut_signal,
    output logic             o_halt,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_inst_count
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t           r_state;
    logic [3:0]       r_wait;
    ctrl_word_t       r_word;
    logic             r_out_valid;
    logic             r_halt;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    ctrl_word_t w_word;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_trap;
    logic       w_accept;
    logic       w_consume;

    ctrl_decode #(.IW(IW)) u_decode (
        .i_instruction (i_instruction),
        .o_word        (w_word),
        .o_is_halt     (w_is_halt),
        .o_is_illegal  (w_is_illegal)
    );

    assign o_in_ready = (r_state == ST_RUN) && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_consume  = r_out_valid && i_out_ready && !i_flush;
    assign w_trap     = TRAP_EN && w_is_illegal;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_wait      <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_halt      <= 1'b0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_consume && !(&r_count)) begin
                r_count <= r_count + 1'b1;
            end

            if (r_state == ST_LOAD_WAIT) begin
                if (i_flush || r_wait == 4'd1) begin
                    r_state <= ST_RUN;
                    r_wait  <= '0;
                end else begin
                    r_wait <= r_wait - 1'b1;
                end
            end

            // Flush squashes both the held word and anything accepted alongside it.
            if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                if (w_is_halt || w_trap) begin
                    r_halt      <= 1'b1;
                    r_illegal   <= w_trap;
                    r_state     <= ST_HALTED;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= 1'b1;
                    r_word      <= w_word;
                    if (w_word.read_mem) begin
                        r_state <= ST_LOAD_WAIT;
                        r_wait  <= LAT;
                    end
                end
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid         = r_out_valid;
    assign o_write_r0          = r_word.write_r0;
    assign o_general_reg_write = r_word.general_reg_write;
    assign o_read_mem          = r_word.read_mem;
    assign o_write_mem         = r_word.write_mem;
    assign o_branch            = r_word.branch;
    assign o_branch_cond       = r_word.branch_cond;
    assign o_lut_signal        = r_word.lut_signal;
    assign o_halt              = r_halt;
    assign o_illegal           = r_illegal;
    assign o_inst_count        = r_count;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe with directed and random stimulus
module tb_ctrl_pipe;

    localparam int IW      = 9;
    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 16;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_in_valid = 1'b0;
    logic             o_in_ready;
    logic [IW-1:0]    i_instruction = '0;
    logic             o_out_valid;
    logic             i_out_ready = 1'b0;
    logic             i_flush = 1'b0;
    logic             o_write_r0, o_general_reg_write, o_read_mem, o_write_mem;
    logic             o_branch, o_branch_cond, o_lut_signal;
    logic             o_halt, o_illegal;
    logic [CNT_W-1:0] o_inst_count;

    always #5 clk = ~clk;

    ctrl_pipe #(.IW(IW), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .i_clk               (clk),
        .i_reset             (i_reset),
        .i_in_valid          (i_in_valid),
        .o_in_ready          (o_in_ready),
        .i_instruction       (i_instruction),
        .o_out_valid         (o_out_valid),
        .i_out_ready         (i_out_ready),
        .i_flush             (i_flush),
        .o_write_r0          (o_write_r0),
        .o_general_reg_write (o_general_reg_write),
        .o_read_mem          (o_read_mem),
        .o_write_mem         (o_write_mem),
        .o_branch            (o_branch),
        .o_branch_cond       (o_branch_cond),
        .o_lut_signal        (o_lut_signal),
        .o_halt              (o_halt),
        .o_illegal           (o_illegal),
        .o_inst_count        (o_inst_count)
    );

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    // Reference state: words owed to execute, load-busy cycles left, halt/illegal, delivered count.
    logic [6:0] exp_q[$];
    int         m_wait = 0;
    bit         m_halted = 1'b0;
    bit         m_illegal = 1'b0;
    int         m_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Control word order: {WriteR0, GeneralRegWrite, ReadMem, WriteMem, Branch, BranchCond, LUTsignal}
    task automatic ref_decode(input logic [IW-1:0] ins, output logic [6:0] w,
                              output bit halt, output bit undef);
        int typ, code_r, code_i;
        halt   = (ins == {IW{1'b1}});
        typ    = int'((ins >> (IW - 2)) & 1);
        code_r = int'((ins >> (IW - 6)) & 15);
        code_i = int'((ins >> (IW - 5)) & 7);
        undef  = 1'b0;
        w      = 7'b0000000;
        if (typ == 1) begin
            case (code_r)
                0, 3, 4, 5, 6, 7, 9, 10, 13: w = 7'b1000000;
                1:       w = 7'b1010000;
                2:       w = 7'b0100000;
                8:       w = 7'b0001000;
                11:      w = 7'b0000110;
                12:      w = 7'b1100000;
                default: undef = 1'b1;
            endcase
        end else begin
            case (code_i)
                0:             w = 7'b1000001;
                1, 2, 4, 5:    w = 7'b1000000;
                3:             w = 7'b0000100;
                default:       undef = 1'b1;
            endcase
        end
    endtask

    // Monitor: retires or drops the owed word whenever the DUT presents one.
    initial begin
        logic [6:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (armed && !i_reset) begin
                chk("out_valid", 32'(o_out_valid), 32'(exp_q.size() > 0));
                if (exp_q.size() > 0 && i_flush) begin
                    void'(exp_q.pop_front());
                end else if (exp_q.size() > 0 && i_out_ready) begin
                    w = exp_q.pop_front();
                    chk("ctrl_word", 32'({o_write_r0, o_general_reg_write, o_read_mem, o_write_mem,
                                          o_branch, o_branch_cond, o_lut_signal}), 32'(w));
                    if (m_count < (1 << CNT_W) - 1) m_count++;
                end
            end
        end
    end

    task automatic cycle(input bit v, input logic [IW-1:0] ins, input bit ordy,
                         input bit fl, input bit rst);
        bit         exp_ready, acc, halt, undef;
        logic [6:0] w;
        @(negedge clk);
        i_in_valid    = v;
        i_instruction = ins;
        i_out_ready   = ordy;
        i_flush       = fl;
        i_reset       = rst;
        #1;
        exp_ready = !m_halted && (m_wait == 0) && (exp_q.size() == 0 || ordy);
        if (armed) begin
            chk("in_ready", 32'(o_in_ready), 32'(exp_ready));
            chk("halt", 32'(o_halt), 32'(m_halted));
            chk("illegal", 32'(o_illegal), 32'(m_illegal));
            chk("inst_count", 32'(o_inst_count), 32'(m_count));
        end
        acc = v && exp_ready;
        #2;
        if (rst) begin
            exp_q.delete();
            m_wait    = 0;
            m_halted  = 1'b0;
            m_illegal = 1'b0;
            m_count   = 0;
        end else begin
            if (fl) m_wait = 0;
            else if (m_wait > 0) m_wait--;
            if (acc && !fl) begin
                ref_decode(ins, w, halt, undef);
                if (halt) begin
                    m_halted = 1'b1;
                end else if (undef && TRAP) begin
                    m_halted  = 1'b1;
                    m_illegal = 1'b1;
                end else begin
                    exp_q.push_back(w);
                    if (w[4]) m_wait = MEM_LAT;
                end
            end
        end
    endtask

    localparam logic [IW-1:0] ADD  = 9'b010000000;
    localparam logic [IW-1:0] LOAD = 9'b010001000;
    localparam logic [IW-1:0] STR  = 9'b011000000;
    localparam logic [IW-1:0] CLR  = 9'b011100000;
    localparam logic [IW-1:0] BR   = 9'b000110000;
    localparam logic [IW-1:0] R14  = 9'b011110000;
    localparam logic [IW-1:0] HLT  = 9'h1FF;

    initial begin
        logic [IW-1:0] ins;
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        armed = 1'b1;
        cycle(0, '0, 0, 0, 0);

        cycle(1, ADD, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, LOAD, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, ADD, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, STR, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, BR, 0, 0, 0);
        cycle(1, BR, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, CLR, 0, 0, 0);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, ADD, 1, 1, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, LOAD, 1, 0, 0);
        cycle(1, ADD, 0, 1, 0);
        cycle(1, ADD, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, HLT, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, ADD, 1, 0, 0);
        cycle(0, '0, 1, 0, 1);
        cycle(0, '0, 1, 0, 0);

        cycle(1, R14, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ins = HLT;
            else ins = IW'($urandom);
            cycle($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0,
                  (m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
